// File: rtl/bomb_spawner.sv
// bomb_spawner: draws LCG values until a free in-grid cell is found, tracks occupancy, offers the cell via valid/ready
module bomb_spawner #(
  parameter int GRID_W    = 16,
  parameter int GRID_H    = 12,
  parameter int MAX_TRIES = 8,
  parameter int SETTLE    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       spawn_req,
  output logic       spawn_busy,
  output logic       rand_change,
  input  logic [7:0] rand_in,
  output logic       spawn_valid,
  input  logic       spawn_ready,
  output logic [3:0] spawn_x,
  output logic [3:0] spawn_y,
  output logic       spawn_fail,
  input  logic       clr_valid,
  input  logic [3:0] clr_x,
  input  logic [3:0] clr_y,
  output logic [7:0] occ_count
);
  typedef enum logic [2:0] {IDLE, PULSE, WAIT, CHECK, OFFER, FAIL} state_t;
  localparam int SW = SETTLE > 1 ? $clog2(SETTLE) : 1;
  localparam logic [SW-1:0] SET_LAST = SW'(SETTLE - 1);
  localparam logic [4:0] GW = 5'(GRID_W);
  localparam logic [4:0] GH = 5'(GRID_H);
  localparam logic [7:0] MT = 8'(MAX_TRIES);
  state_t state_q, state_d;
  logic [SW-1:0] wait_q, wait_d;
  logic [7:0] tries_q, tries_d, occ_count_q, occ_count_d;
  logic [255:0] occ_q, occ_d;
  logic [3:0] spawn_x_q, spawn_x_d, spawn_y_q, spawn_y_d;
  logic rand_change_q, rand_change_d, spawn_valid_q, spawn_valid_d;
  logic spawn_fail_q, spawn_fail_d, spawn_busy_q, spawn_busy_d;
  logic legal, mark, clr_hit;
  // bitmap is indexed {y,x}; only in-grid bits can ever be set
  assign legal   = ({1'b0, rand_in[3:0]} < GW) && ({1'b0, rand_in[7:4]} < GH) && !occ_q[rand_in];
  assign mark    = (state_q == CHECK) && legal;
  assign clr_hit = clr_valid && ({1'b0, clr_x} < GW) && ({1'b0, clr_y} < GH) && occ_q[{clr_y, clr_x}];
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      wait_q        <= '0;
      tries_q       <= '0;
      occ_q         <= '0;
      occ_count_q   <= '0;
      spawn_x_q     <= '0;
      spawn_y_q     <= '0;
      rand_change_q <= 1'b0;
      spawn_valid_q <= 1'b0;
      spawn_fail_q  <= 1'b0;
      spawn_busy_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_q        <= wait_d;
      tries_q       <= tries_d;
      occ_q         <= occ_d;
      occ_count_q   <= occ_count_d;
      spawn_x_q     <= spawn_x_d;
      spawn_y_q     <= spawn_y_d;
      rand_change_q <= rand_change_d;
      spawn_valid_q <= spawn_valid_d;
      spawn_fail_q  <= spawn_fail_d;
      spawn_busy_q  <= spawn_busy_d;
    end
  end
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    tries_d = tries_q;
    case (state_q)
      IDLE:  if (spawn_req) begin
               state_d = PULSE;
               tries_d = '0;
             end
      PULSE: begin
               state_d = WAIT;
               wait_d  = '0;
             end
      WAIT:  if (wait_q == SET_LAST) state_d = CHECK;
             else wait_d = wait_q + SW'(1);
      CHECK: if (legal) state_d = OFFER;
             else if (tries_q + 8'd1 < MT) begin
               state_d = PULSE;
               tries_d = tries_q + 8'd1;
             end else state_d = FAIL;
      OFFER: state_d = spawn_ready ? IDLE : OFFER;
      FAIL:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // outputs are decoded from the next state so every output leaves a flop
  always_comb begin
    rand_change_d = state_d == PULSE;
    spawn_valid_d = state_d == OFFER;
    spawn_fail_d  = state_d == FAIL;
    spawn_busy_d  = state_d != IDLE;
    spawn_x_d     = mark ? rand_in[3:0] : spawn_x_q;
    spawn_y_d     = mark ? rand_in[7:4] : spawn_y_q;
    occ_d         = occ_q;
    if (clr_hit) occ_d[{clr_y, clr_x}] = 1'b0;
    if (mark) occ_d[rand_in] = 1'b1;
    occ_count_d   = occ_count_q + 8'(mark) - 8'(clr_hit);
  end
  assign rand_change = rand_change_q;
  assign spawn_valid = spawn_valid_q;
  assign spawn_fail  = spawn_fail_q;
  assign spawn_busy  = spawn_busy_q;
  assign spawn_x     = spawn_x_q;
  assign spawn_y     = spawn_y_q;
  assign occ_count   = occ_count_q;
endmodule

// File: tb/tb_bomb_spawner.sv
// tb_bomb_spawner: directed scenarios against an LCG model with a scoreboard of expected spawn cells
module tb_bomb_spawner;
  logic clk = 1'b0, rst = 1'b0, spawn_req = 1'b0, spawn_ready = 1'b1, clr_valid = 1'b0;
  logic [3:0] clr_x = '0, clr_y = '0, spawn_x, spawn_y;
  logic [7:0] rand_in, occ_count, force_val = '0;
  logic [7:0] lcg = 8'd8;
  logic force_en = 1'b0;
  logic spawn_busy, rand_change, spawn_valid, spawn_fail;
  int total = 0, passed = 0, hs = 0, h0;
  logic [7:0] exp_q[$];

  bomb_spawner #(.MAX_TRIES(2)) dut (
    .clk(clk), .rst(rst), .spawn_req(spawn_req), .spawn_busy(spawn_busy),
    .rand_change(rand_change), .rand_in(rand_in), .spawn_valid(spawn_valid),
    .spawn_ready(spawn_ready), .spawn_x(spawn_x), .spawn_y(spawn_y),
    .spawn_fail(spawn_fail), .clr_valid(clr_valid), .clr_x(clr_x), .clr_y(clr_y),
    .occ_count(occ_count)
  );

  always #5 clk = ~clk;
  always @(posedge rand_change or negedge rst)
    if (!rst) lcg <= 8'd8;
    else lcg <= 8'(lcg * 8'd5 + 8'd3);
  assign rand_in = force_en ? force_val : lcg;
  always @(posedge clk) if (rst && spawn_valid && spawn_ready) hs++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // issues one request; checks latency (samples after acceptance), pulse count, result and occupancy
  task automatic do_req(input string tag, input int exp_lat, input int exp_pulses, input logic exp_fail,
                        input int clr_at, input logic [3:0] cx, input logic [3:0] cy,
                        input logic [7:0] exp_cell, input logic [7:0] exp_occ);
    int lat = -1, pulses = 0;
    logic [7:0] e;
    spawn_req = 1'b1;
    if (!exp_fail) exp_q.push_back(exp_cell);
    @(negedge clk);
    spawn_req = 1'b0;
    for (int i = 0; i < 40 && lat < 0; i++) begin
      clr_valid = (i == clr_at);
      clr_x = cx;
      clr_y = cy;
      if (rand_change) pulses++;
      if (spawn_valid || spawn_fail) lat = i;
      else @(negedge clk);
    end
    clr_valid = 1'b0;
    chk({tag, " latency"}, lat, exp_lat);
    chk({tag, " pulses"}, pulses, exp_pulses);
    chk({tag, " fail"}, spawn_fail, exp_fail);
    chk({tag, " valid"}, spawn_valid, !exp_fail);
    chk({tag, " occ"}, occ_count, exp_occ);
    if (spawn_valid && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, " x"}, spawn_x, e[3:0]);
      chk({tag, " y"}, spawn_y, e[7:4]);
    end
    if (spawn_ready) begin
      @(negedge clk);
      chk({tag, " post busy"}, spawn_busy, 0);
      chk({tag, " post valid"}, spawn_valid, 0);
      chk({tag, " post fail"}, spawn_fail, 0);
    end
  endtask

  task automatic clr_cell(input logic [3:0] cx, input logic [3:0] cy, input logic [7:0] exp_occ);
    clr_valid = 1'b1;
    clr_x = cx;
    clr_y = cy;
    @(negedge clk);
    clr_valid = 1'b0;
    @(negedge clk);
    chk("clear occ", occ_count, exp_occ);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst rand_change", rand_change, 0);
    chk("rst valid", spawn_valid, 0);
    chk("rst fail", spawn_fail, 0);
    chk("rst busy", spawn_busy, 0);
    chk("rst x", spawn_x, 0);
    chk("rst y", spawn_y, 0);
    chk("rst occ", occ_count, 0);
    rst = 1'b1;
    @(negedge clk);
    do_req("first", 3, 1, 0, -1, 0, 0, 8'h2B, 1);
    do_req("retry", 6, 2, 0, -1, 0, 0, 8'h45, 2);
    force_en = 1'b1;
    force_val = 8'hF0;
    do_req("exhaust", 6, 2, 1, -1, 0, 0, 8'h00, 2);
    // backpressure with a mid-offer clear of the offered cell and an ignored request
    spawn_ready = 1'b0;
    force_val = 8'h37;
    do_req("bp", 3, 1, 0, -1, 0, 0, 8'h37, 3);
    h0 = hs;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      spawn_req = (i == 4);
      clr_valid = (i == 2);
      clr_x = 4'd7;
      clr_y = 4'd3;
      chk("bp hold valid", spawn_valid, 1);
      chk("bp hold x", spawn_x, 7);
      chk("bp hold y", spawn_y, 3);
    end
    spawn_req = 1'b0;
    clr_valid = 1'b0;
    @(negedge clk);
    chk("bp clear occ", occ_count, 2);
    chk("bp no transfer", hs, h0);
    spawn_ready = 1'b1;
    @(negedge clk);
    chk("bp done valid", spawn_valid, 0);
    chk("bp done busy", spawn_busy, 0);
    repeat (4) @(negedge clk);
    chk("bp req ignored", spawn_busy, 0);
    chk("bp one transfer", hs, h0 + 1);
    clr_cell(4'd11, 4'd2, 1);
    force_val = 8'h2B;
    do_req("mark same", 3, 1, 0, 2, 4'd11, 4'd2, 8'h2B, 2);
    do_req("occupied", 6, 2, 1, -1, 0, 0, 8'h00, 2);
    force_val = 8'h61;
    do_req("mark other", 3, 1, 0, 2, 4'd5, 4'd4, 8'h61, 2);
    force_val = 8'h45;
    do_req("refill", 3, 1, 0, -1, 0, 0, 8'h45, 3);
    clr_cell(4'd0, 4'd12, 3);
    clr_cell(4'd12, 4'd0, 3);
    clr_cell(4'd7, 4'd3, 3);
    // asynchronous reset while waiting for a draw to settle
    force_val = 8'hF0;
    spawn_req = 1'b1;
    @(negedge clk);
    spawn_req = 1'b0;
    @(negedge clk);
    chk("wait busy", spawn_busy, 1);
    rst = 1'b0;
    #1;
    chk("async rand_change", rand_change, 0);
    chk("async valid", spawn_valid, 0);
    chk("async fail", spawn_fail, 0);
    chk("async busy", spawn_busy, 0);
    chk("async x", spawn_x, 0);
    chk("async y", spawn_y, 0);
    chk("async occ", occ_count, 0);
    @(negedge clk);
    rst = 1'b1;
    force_en = 1'b0;
    @(negedge clk);
    do_req("after reset", 3, 1, 0, -1, 0, 0, 8'h2B, 1);
    chk("scoreboard drained", exp_q.size(), 0);
    chk("transfers", hs, 7);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
